fifo_tx_feeder: RTL and testbench

- Read-side consumer of the async FIFO, running in the TX clock domain. Handles one byte per transfer.
- Pops one byte when the FIFO is non-empty and the UART transmitter is idle, then presents it with a one-cycle valid strobe.
- Tracks the transmitter's busy cycle before the next pop. Counts completed bytes and flags a transmitter that never acknowledges.

---
 rtl/fifo_tx_feeder.sv | 115 +++++++++++
 tb/tb_fifo_tx_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_feeder.sv
// Read-side consumer of the async FIFO in the TX clock domain: pops one byte
// when the transmitter is idle, strobes it out and follows busy high then low.
module fifo_tx_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  output logic                  R_inc,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int TO_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rinc;
  logic                  w_rinc_next;
  logic                  r_valid;
  logic                  w_valid_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic [TO_W-1:0]       r_to_cnt;
  logic [TO_W-1:0]       w_to_cnt_next;
  logic                  r_err;
  logic                  w_err_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_rinc   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rinc   <= w_rinc_next;
      r_valid  <= w_valid_next;
      r_data   <= w_data_next;
      r_count  <= w_count_next;
      r_to_cnt <= w_to_cnt_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rinc_next   = 1'b0;
    w_valid_next  = 1'b0;
    w_data_next   = r_data;
    w_count_next  = r_count;
    w_to_cnt_next = r_to_cnt;
    // Clear first so that a timeout raised in the same cycle overrides it.
    w_err_next    = r_err & ~clr_err;
    case (r_state)
      S_IDLE: begin
        if (en && !empty && !busy) begin
          w_data_next  = R_data;
          w_rinc_next  = 1'b1;
          w_valid_next = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        w_to_cnt_next = '0;
        w_state_next  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (busy) begin
          w_state_next = S_WAIT_LO;
        end else if (r_to_cnt == TO_LAST) begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!busy) begin
          w_count_next = r_count + 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign R_inc       = r_rinc;
  assign tx_valid    = r_valid;
  assign tx_data     = r_data;
  assign tx_count    = r_count;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Directed bench for fifo_tx_feeder: FIFO and transmitter models, a gating
// vector table, and hand-written timeout, reset and counter-wrap sequences.
module tb_fifo_tx_feeder;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 8;
  localparam int BL = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          busy;
  logic          clr_err = 1'b0;
  logic          busy_force = 1'b0;
  logic          busy_model = 1'b0;
  logic          auto_busy = 1'b1;
  int            busy_len = BL;

  logic          r_inc, tx_valid, timeout_err;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] tx_count;
  logic          r_inc2, tx_valid2, timeout_err2;
  logic [DW-1:0] tx_data2;
  logic [1:0]    tx_count2;

  assign busy = busy_force | busy_model;

  always #5 clk = ~clk;

  fifo_tx_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BUSY_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .en(en), .empty(empty), .R_data(r_data),
    .R_inc(r_inc), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_count(tx_count), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  fifo_tx_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(2), .BUSY_TIMEOUT(TO)) dut2 (
    .CLK(clk), .RST(rst), .en(en), .empty(empty), .R_data(r_data),
    .R_inc(r_inc2), .busy(busy), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_count(tx_count2), .timeout_err(timeout_err2), .clr_err(clr_err)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_q[$];
  int   n_valid = 0, n_rinc = 0, n_pair_bad = 0, n_busy_at_valid = 0, n_dut2_bad = 0;
  int   min_gap = 1000000, last_valid_cyc = 0, cyc = 0;
  int   bz_delay = 0, bz_rem = 0;
  logic prev_rinc = 1'b0;

  // FIFO and transmitter models; busy rises one cycle after tx_valid.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      busy_model = 1'b0;
      bz_delay   = 0;
      bz_rem     = 0;
      prev_rinc  = 1'b0;
    end else begin
      if (r_inc !== tx_valid) n_pair_bad = n_pair_bad + 1;
      if (r_inc && prev_rinc) n_pair_bad = n_pair_bad + 1;
      prev_rinc = r_inc;
      if (r_inc2 !== r_inc || tx_valid2 !== tx_valid || tx_data2 !== tx_data ||
          timeout_err2 !== timeout_err)
        n_dut2_bad = n_dut2_bad + 1;
      if (r_inc) begin
        n_rinc = n_rinc + 1;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        else n_pair_bad = n_pair_bad + 1;
      end
      if (tx_valid) begin
        n_valid = n_valid + 1;
        got_q.push_back(tx_data);
        if (busy) n_busy_at_valid = n_busy_at_valid + 1;
        if (n_valid > 1 && (cyc - last_valid_cyc) < min_gap) min_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (bz_rem > 0) begin
        bz_rem = bz_rem - 1;
        if (bz_rem == 0) busy_model = 1'b0;
      end
      if (bz_delay > 0) begin
        bz_delay = bz_delay - 1;
        if (bz_delay == 0) begin
          busy_model = 1'b1;
          bz_rem     = busy_len;
        end
      end
      if (tx_valid && auto_busy) bz_delay = 1;
    end
    empty  = (fifo_q.size() == 0);
    r_data = empty ? '0 : fifo_q[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [CW-1:0] target, input int budget, input string name);
    int k = 0;
    while (tx_count !== target && k < budget) begin
      tick(1);
      k = k + 1;
    end
    chk(name, 32'(tx_count), 32'(target));
  endtask

  typedef struct {
    logic          en;
    logic          bf;
    logic          fill;
    logic [DW-1:0] data;
    int            exp_pop;
  } vec_t;

  vec_t vecs[5];
  int   wrap_exp[5];

  initial begin
    int base_r, base_c;

    vecs[0] = '{en: 1'b1, bf: 1'b1, fill: 1'b1, data: 8'h11, exp_pop: 0};
    vecs[1] = '{en: 1'b0, bf: 1'b0, fill: 1'b1, data: 8'h22, exp_pop: 0};
    vecs[2] = '{en: 1'b1, bf: 1'b0, fill: 1'b0, data: 8'h33, exp_pop: 0};
    vecs[3] = '{en: 1'b0, bf: 1'b1, fill: 1'b1, data: 8'h44, exp_pop: 0};
    vecs[4] = '{en: 1'b1, bf: 1'b0, fill: 1'b1, data: 8'h5A, exp_pop: 1};
    wrap_exp = '{1, 2, 3, 0, 1};

    // Reset state
    tick(3);
    chk("reset_rinc", 32'(r_inc), 0);
    chk("reset_valid", 32'(tx_valid), 0);
    chk("reset_data", 32'(tx_data), 0);
    chk("reset_count", 32'(tx_count), 0);
    chk("reset_err", 32'(timeout_err), 0);
    rst = 1'b0;
    tick(2);

    // Basic pop
    fifo_q.push_back(8'hA5);
    en = 1'b1;
    wait_cnt(1, 60, "basic_count");
    chk("basic_rinc_n", 32'(n_rinc), 1);
    chk("basic_data", 32'(got_q[got_q.size()-1]), 32'hA5);
    chk("basic_hold", 32'(tx_data), 32'hA5);
    chk("basic_fifo_empty", 32'(fifo_q.size()), 0);
    chk("basic_count2", 32'(tx_count2), 1);
    $display("basic: byte 0x%0h sent, tx_count=%0d", tx_data, tx_count);

    // Burst of three
    base_r = n_rinc;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03);
    wait_cnt(4, 200, "burst_count");
    tick(5);
    chk("burst_rinc_n", 32'(n_rinc - base_r), 3);
    chk("burst_b0", 32'(got_q[got_q.size()-3]), 1);
    chk("burst_b1", 32'(got_q[got_q.size()-2]), 2);
    chk("burst_b2", 32'(got_q[got_q.size()-1]), 3);
    chk("burst_gap", 32'(min_gap >= BL + 3), 1);
    chk("burst_count2", 32'(tx_count2), 0);
    $display("burst: 3 bytes sent, min spacing %0d cycles", min_gap);

    // Gating vectors in IDLE
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      busy_force = 1'b0;
      fifo_q.delete();
      if (vecs[i].fill) fifo_q.push_back(vecs[i].data);
      tick(2);
      base_r = n_rinc;
      base_c = int'(tx_count);
      en = vecs[i].en;
      busy_force = vecs[i].bf;
      tick(1);
      chk($sformatf("vec%0d_latency", i), 32'(r_inc), 32'(vecs[i].exp_pop));
      tick(30);
      chk($sformatf("vec%0d_pops", i), 32'(n_rinc - base_r), 32'(vecs[i].exp_pop));
      chk($sformatf("vec%0d_count", i), 32'(int'(tx_count) - base_c), 32'(vecs[i].exp_pop));
      if (vecs[i].exp_pop != 0)
        chk($sformatf("vec%0d_data", i), 32'(got_q[got_q.size()-1]), 32'(vecs[i].data));
      $display("vec %0d: en=%0b busy=%0b fill=%0b pops=%0d", i, vecs[i].en, vecs[i].bf,
               vecs[i].fill, n_rinc - base_r);
    end
    busy_force = 1'b0;

    // Timeout: busy never rises
    auto_busy = 1'b0;
    fifo_q.push_back(8'h77);
    tick(1);
    chk("to_valid", 32'(tx_valid), 1);
    tick(1);
    chk("to_err_entry", 32'(timeout_err), 0);
    tick(TO - 1);
    chk("to_err_early", 32'(timeout_err), 0);
    tick(1);
    chk("to_err_set", 32'(timeout_err), 1);
    chk("to_count_same", 32'(tx_count), 5);
    chk("to_fifo_empty", 32'(fifo_q.size()), 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("to_clr", 32'(timeout_err), 0);
    $display("timeout: flagged after %0d cycles and cleared", TO);

    // Second timeout with clr_err in the same cycle
    fifo_q.push_back(8'h66);
    tick(1);
    chk("to2_valid", 32'(tx_valid), 1);
    tick(TO);
    chk("to2_err_early", 32'(timeout_err), 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("to2_set_wins", 32'(timeout_err), 1);
    tick(1);
    chk("to2_sticky", 32'(timeout_err), 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("to2_clr", 32'(timeout_err), 0);
    $display("timeout: set beat simultaneous clear");

    // Back in IDLE after timeout
    auto_busy = 1'b1;
    fifo_q.push_back(8'h99);
    wait_cnt(6, 60, "post_to_count");
    chk("post_to_data", 32'(got_q[got_q.size()-1]), 32'h99);

    // Reset during WAIT_LO
    busy_len = 20;
    fifo_q.push_back(8'hC3);
    tick(1);
    chk("rst_pre_valid", 32'(tx_valid), 1);
    tick(5);
    rst = 1'b1;
    #1;
    chk("rst_rinc", 32'(r_inc), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_count", 32'(tx_count), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_count2", 32'(tx_count2), 0);
    tick(2);
    rst = 1'b0;
    busy_len = BL;
    fifo_q.push_back(8'h3C);
    wait_cnt(1, 60, "rst_after_count");
    chk("rst_after_data", 32'(got_q[got_q.size()-1]), 32'h3C);
    $display("reset: mid-transfer reset recovered, next byte 0x3c sent");

    // Counter wrap on the 2-bit instance
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      fifo_q.push_back(8'(8'h10 + k));
      wait_cnt(CW'(k + 1), 60, $sformatf("wrap_count%0d", k));
      chk($sformatf("wrap_cnt2_%0d", k), 32'(tx_count2), 32'(wrap_exp[k]));
      $display("wrap: byte %0d sent, 2-bit count=%0d", k, tx_count2);
    end

    tick(3);
    chk("pairing", 32'(n_pair_bad), 0);
    chk("busy_at_valid", 32'(n_busy_at_valid), 0);
    chk("valid_eq_rinc", 32'(n_valid), 32'(n_rinc));
    chk("dut2_agree", 32'(n_dut2_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
